// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the hardwired ALU control sequencer.
// State numbering is what appears on state_dbg.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StRst  = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StT6   = 4'd7,
        StHalt = 4'd8
    } state_e;

    localparam logic [4:0] OpAdd  = 5'h03;
    localparam logic [4:0] OpSub  = 5'h04;
    localparam logic [4:0] OpAnd  = 5'h05;
    localparam logic [4:0] OpOr   = 5'h06;
    localparam logic [4:0] OpShr  = 5'h07;
    localparam logic [4:0] OpShl  = 5'h08;
    localparam logic [4:0] OpMul  = 5'h0F;
    localparam logic [4:0] OpDiv  = 5'h10;
    localparam logic [4:0] OpNop  = 5'h1A;
    localparam logic [4:0] OpHalt = 5'h1B;

    localparam logic [3:0] AluNone = 4'd0;
    localparam logic [3:0] AluAdd  = 4'd3;
    localparam logic [3:0] AluSub  = 4'd4;
    localparam logic [3:0] AluAnd  = 4'd5;
    localparam logic [3:0] AluOr   = 4'd6;
    localparam logic [3:0] AluShr  = 4'd7;
    localparam logic [3:0] AluShl  = 4'd8;
    localparam logic [3:0] AluMul  = 4'd9;
    localparam logic [3:0] AluDiv  = 4'd10;

    localparam int unsigned IrOpMsb = 31;
    localparam int unsigned IrOpLsb = 27;
    localparam int unsigned IrRaMsb = 26;
    localparam int unsigned IrRaLsb = 23;
    localparam int unsigned IrRbMsb = 22;
    localparam int unsigned IrRbLsb = 19;
    localparam int unsigned IrRcMsb = 18;
    localparam int unsigned IrRcLsb = 15;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decode: instruction class, ALU operation, HI/LO usage,
// and one-hot register selects (index >= NUM_REGS selects nothing).
module instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic [4:0]          opcode,
    input  logic [3:0]          ra,
    input  logic [3:0]          rb,
    input  logic [3:0]          rc,
    output logic                is_alu,
    output logic                is_halt,
    output logic [3:0]          alu_op,
    output logic                uses_hilo,
    output logic [NUM_REGS-1:0] ra_oh,
    output logic [NUM_REGS-1:0] rb_oh,
    output logic [NUM_REGS-1:0] rc_oh
);

    always_comb begin
        is_alu    = 1'b0;
        is_halt   = 1'b0;
        alu_op    = AluNone;
        uses_hilo = 1'b0;
        case (opcode)
            OpAdd:   begin is_alu = 1'b1; alu_op = AluAdd; end
            OpSub:   begin is_alu = 1'b1; alu_op = AluSub; end
            OpAnd:   begin is_alu = 1'b1; alu_op = AluAnd; end
            OpOr:    begin is_alu = 1'b1; alu_op = AluOr;  end
            OpShr:   begin is_alu = 1'b1; alu_op = AluShr; end
            OpShl:   begin is_alu = 1'b1; alu_op = AluShl; end
            OpMul:   begin is_alu = 1'b1; alu_op = AluMul; uses_hilo = 1'b1; end
            OpDiv:   begin is_alu = 1'b1; alu_op = AluDiv; uses_hilo = 1'b1; end
            OpHalt:  is_halt = 1'b1;
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_onehot
        assign ra_oh[i] = ({28'd0, ra} == 32'(i));
        assign rb_oh[i] = ({28'd0, rb} == 32'(i));
        assign rc_oh[i] = ({28'd0, rc} == 32'(i));
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired T-state control unit for the bus datapath: fetch T0-T2, execute T3-T6.
// Optional CTRL_MEM_WAIT_EN stretches T1 until mem_ready.
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCin,
    output logic                PCout,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [3:0]          ALUop,
    output logic                run,
    output logic [3:0]          state_dbg
);

    state_e state_q, state_d;

    logic                is_alu, is_halt, uses_hilo;
    logic [3:0]          dec_alu_op;
    logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;

    logic unused_ir;
    assign unused_ir = ^ir[IrRcLsb-1:0];

    instr_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_instr_decode (
        .opcode    (ir[IrOpMsb:IrOpLsb]),
        .ra        (ir[IrRaMsb:IrRaLsb]),
        .rb        (ir[IrRbMsb:IrRbLsb]),
        .rc        (ir[IrRcMsb:IrRcLsb]),
        .is_alu    (is_alu),
        .is_halt   (is_halt),
        .alu_op    (dec_alu_op),
        .uses_hilo (uses_hilo),
        .ra_oh     (ra_oh),
        .rb_oh     (rb_oh),
        .rc_oh     (rc_oh)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CTRL_MEM_WAIT_EN
    // Zero on the first T1 cycle, so it doubles as the "first cycle" flag.
    logic [3:0] wait_cnt_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wait_cnt_q <= 4'd0;
        end else if (state_q == StT1 && !mem_ready) begin
            wait_cnt_q <= (wait_cnt_q == 4'd15) ? 4'd15 : wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_q <= 4'd0;
        end
    end

    assign state_dbg = (state_q == StT1 && wait_cnt_q != 4'd0) ? wait_cnt_q : state_q;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign state_dbg        = state_q;
`endif

    always_comb begin
        state_d  = state_q;
        Rin      = '0;
        Rout     = '0;
        PCin     = 1'b0;
        PCout    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        ALUop    = AluNone;
        run      = 1'b0;
        unique case (state_q)
            StRst: state_d = StT0;
            StT0: begin
                run     = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                ALUop   = AluAdd;
                state_d = StT1;
            end
            StT1: begin
                run   = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
`ifdef CTRL_MEM_WAIT_EN
                if (wait_cnt_q == 4'd0) begin
                    PCin    = 1'b1;
                    Zlowout = 1'b1;
                end
                state_d = mem_ready ? StT2 : StT1;
`else
                PCin    = 1'b1;
                Zlowout = 1'b1;
                state_d = StT2;
`endif
            end
            StT2: begin
                run     = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                run = 1'b1;
                if (is_alu) begin
                    Rout    = rb_oh;
                    Yin     = 1'b1;
                    state_d = StT4;
                end else if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StT0;
                end
            end
            StT4: begin
                run     = 1'b1;
                Rout    = rc_oh;
                ALUop   = dec_alu_op;
                Zlowin  = 1'b1;
                Zhighin = uses_hilo;
                state_d = StT5;
            end
            StT5: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                if (uses_hilo) begin
                    LOin    = 1'b1;
                    state_d = StT6;
                end else begin
                    Rin     = ra_oh;
                    state_d = StT0;
                end
            end
            StT6: begin
                run      = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = StT0;
            end
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed, table-driven bench for alu_control_sequencer; the mem-wait
// sequence runs only when CTRL_MEM_WAIT_EN is defined.
module tb_alu_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] Rin, Rout;
    logic PCin, PCout, MARin, MDRin, MDRout, IRin, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read;
    logic [3:0]  ALUop;
    logic        run;
    logic [3:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    alu_control_sequencer #(.NUM_REGS(16)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .ALUop(ALUop),
        .run(run), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Bit order: PCin PCout MARin MDRin MDRout IRin Yin Zlowin Zhighin Zlowout
    //            Zhighout HIin LOin IncPC Read
    logic [14:0] stb;
    assign stb = {PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin,
                  Zlowout, Zhighout, HIin, LOin, IncPC, Read};

    localparam logic [14:0] SPcin = 15'h4000, SPcout = 15'h2000, SMarin = 15'h1000;
    localparam logic [14:0] SMdrin = 15'h0800, SMdrout = 15'h0400, SIrin = 15'h0200;
    localparam logic [14:0] SYin = 15'h0100, SZlin = 15'h0080, SZhin = 15'h0040;
    localparam logic [14:0] SZlout = 15'h0020, SZhout = 15'h0010, SHiin = 15'h0008;
    localparam logic [14:0] SLoin = 15'h0004, SInc = 15'h0002, SRead = 15'h0001;
    localparam logic [14:0] StbT0 = SPcout | SMarin | SInc | SZlin;
    localparam logic [14:0] StbT1 = SZlout | SPcin | SRead | SMdrin;
    localparam logic [14:0] StbT2 = SMdrout | SIrin;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  st;
        logic        run;
        logic [14:0] stb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [3:0]  alu;
    } vec_t;

    vec_t vecs[$];

    function automatic void push(logic [31:0] i, logic [3:0] st, logic r, logic [14:0] s,
                                 logic [15:0] ri, logic [15:0] ro, logic [3:0] a);
        vec_t v;
        v.ir = i; v.st = st; v.run = r; v.stb = s; v.rin = ri; v.rout = ro; v.alu = a;
        vecs.push_back(v);
    endfunction

    // kind: 0 = ALU, 1 = NOP/undefined, 2 = HALT (followed by 10 halted cycles)
    function automatic void add_instr(logic [31:0] i, int kind, logic [15:0] ra_oh,
                                      logic [15:0] rb_oh, logic [15:0] rc_oh,
                                      logic [3:0] a, logic hilo);
        push(i, 4'd1, 1'b1, StbT0, 16'h0, 16'h0, 4'd3);
        push(i, 4'd2, 1'b1, StbT1, 16'h0, 16'h0, 4'd0);
        push(i, 4'd3, 1'b1, StbT2, 16'h0, 16'h0, 4'd0);
        if (kind == 0) begin
            push(i, 4'd4, 1'b1, SYin, 16'h0, rb_oh, 4'd0);
            push(i, 4'd5, 1'b1, hilo ? (SZlin | SZhin) : SZlin, 16'h0, rc_oh, a);
            if (hilo) begin
                push(i, 4'd6, 1'b1, SZlout | SLoin, 16'h0, 16'h0, 4'd0);
                push(i, 4'd7, 1'b1, SZhout | SHiin, 16'h0, 16'h0, 4'd0);
            end else begin
                push(i, 4'd6, 1'b1, SZlout, ra_oh, 16'h0, 4'd0);
            end
        end else begin
            push(i, 4'd4, 1'b1, 15'h0, 16'h0, 16'h0, 4'd0);
            if (kind == 2) begin
                for (int k = 0; k < 10; k++) push(i, 4'd8, 1'b0, 15'h0, 16'h0, 16'h0, 4'd0);
            end
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(string nm);
        chk({nm, ".state"}, 32'(state_dbg), 32'd0);
        chk({nm, ".run"}, 32'(run), 32'd0);
        chk({nm, ".stb"}, 32'(stb), 32'd0);
        chk({nm, ".rin"}, 32'(Rin), 32'd0);
        chk({nm, ".rout"}, 32'(Rout), 32'd0);
        chk({nm, ".alu"}, 32'(ALUop), 32'd0);
    endtask

    initial begin
        clear     = 1'b0;
        ir        = 32'h0;
        mem_ready = 1'b1;

        add_instr(32'h192B0000, 0, 16'h0004, 16'h0020, 16'h0040, 4'd3, 1'b0);  // ADD R2,R5,R6
        add_instr(32'h23B88000, 0, 16'h0080, 16'h0080, 16'h0002, 4'd4, 1'b0);  // SUB R7,R7,R1
        add_instr(32'h40918000, 0, 16'h0002, 16'h0004, 16'h0008, 4'd8, 1'b0);  // SHL R1,R2,R3
        add_instr(32'h781A0000, 0, 16'h0000, 16'h0008, 16'h0010, 4'd9, 1'b1);  // MUL R3*R4
        add_instr(32'h87878000, 0, 16'h0000, 16'h0001, 16'h8000, 4'd10, 1'b1); // DIV R0/R15
        add_instr(32'hD0000000, 1, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0);           // NOP
        add_instr(32'hF8000000, 1, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0);           // opcode 1F
        add_instr(32'hD8000000, 2, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0);           // HALT

        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 chk_idle("reset");
        clear = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            ir = vecs[i].ir;
            #1;
            chk($sformatf("v%0d.state", i), 32'(state_dbg), 32'(vecs[i].st));
            chk($sformatf("v%0d.run", i), 32'(run), 32'(vecs[i].run));
            chk($sformatf("v%0d.stb", i), 32'(stb), 32'(vecs[i].stb));
            chk($sformatf("v%0d.rin", i), 32'(Rin), 32'(vecs[i].rin));
            chk($sformatf("v%0d.rout", i), 32'(Rout), 32'(vecs[i].rout));
            chk($sformatf("v%0d.alu", i), 32'(ALUop), 32'(vecs[i].alu));
        end

        // Clear pulse leaves HALT and restarts at T0.
        @(negedge clock);
        clear = 1'b0;
        #1 chk_idle("halt_clear");
        @(negedge clock);
        clear = 1'b1;
        ir    = 32'h192B0000;
        @(negedge clock);
        #1 chk("restart.state", 32'(state_dbg), 32'd1);

        // Asynchronous reset in the middle of T4 of an ADD.
        repeat (4) @(negedge clock);
        #1;
        chk("midop.t4.state", 32'(state_dbg), 32'd5);
        chk("midop.t4.rout", 32'(Rout), 32'h0040);
        #2 clear = 1'b0;
        #1 chk_idle("midop.async");
        @(posedge clock);
        #1 chk("midop.after_edge.rin", 32'(Rin), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        #1 chk("midop.restart.state", 32'(state_dbg), 32'd1);

`ifdef CTRL_MEM_WAIT_EN
        // In T0 now: stall T1 for three cycles.
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c == 3) mem_ready = 1'b1;
            #1;
            chk($sformatf("wait%0d.pcin", c), 32'(PCin), (c == 0) ? 32'd1 : 32'd0);
            chk($sformatf("wait%0d.read", c), 32'(Read), 32'd1);
            chk($sformatf("wait%0d.irin", c), 32'(IRin), 32'd0);
            chk($sformatf("wait%0d.dbg", c), 32'(state_dbg), (c == 0) ? 32'd2 : 32'(c));
        end
        @(negedge clock);
        #1;
        chk("wait.t2.irin", 32'(IRin), 32'd1);
        chk("wait.t2.state", 32'(state_dbg), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
